// File: rtl/axis_pkg.sv
// Shared width helpers for the AXI-Stream packet FIFO.
// Provides keep width, counter width and RAM entry width.
package axis_pkg;

  function automatic int KEEP_W(input int dw);
    return dw / 8;
  endfunction

  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // RAM entry layout: {tlast, tkeep, tdata}
  function automatic int ENTRY_W(input int dw);
    return dw + KEEP_W(dw) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: sync write, async read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module axis_fifo_ram #(
  parameter int W     = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO, stream or store-and-forward packet mode.
// Ports: axis_aclk/axis_areset, s_axis_*, m_axis_*, occupancy, pkt_count, almost_full.
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int PACKET_MODE    = 0,
  parameter int ALMOST_FULL_TH = DEPTH - 2
) (
  input  logic                          axis_aclk,
  input  logic                          axis_areset,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_W(DATA_WIDTH)-1:0] s_axis_tkeep,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_W(DATA_WIDTH)-1:0] m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [CNT_W(DEPTH)-1:0]       occupancy,
  output logic [CNT_W(DEPTH)-1:0]       pkt_count,
  output logic                          almost_full
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = CNT_W(DEPTH);
  localparam int EW  = ENTRY_W(DATA_WIDTH);
  localparam bit PKT = (PACKET_MODE != 0);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ_nxt;
  logic [CW-1:0] pkt_nxt;
  logic [EW-1:0] rd_entry;
  logic          rdy_q;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic          wr_last;
  logic          rd_last;

  assign full  = (occupancy == CW'(DEPTH));
  assign empty = (occupancy == '0);

  // rdy_q holds ready low until the first edge after reset release
  assign s_axis_tready = rdy_q && !full;

  // Full term releases over-long packets cut-through
  assign m_axis_tvalid = !empty &&
    (!PKT || (pkt_count != '0) || full);

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_entry;

  assign wr_en   = s_axis_tvalid && s_axis_tready;
  assign rd_en   = m_axis_tvalid && m_axis_tready;
  assign wr_last = wr_en && s_axis_tlast;
  assign rd_last = rd_en && m_axis_tlast;

  always_comb begin
    occ_nxt = occupancy;
    pkt_nxt = pkt_count;
    if (wr_en && !rd_en) occ_nxt = occupancy + CW'(1);
    if (!wr_en && rd_en) occ_nxt = occupancy - CW'(1);
    if (wr_last && !rd_last) pkt_nxt = pkt_count + CW'(1);
    if (!wr_last && rd_last) pkt_nxt = pkt_count - CW'(1);
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      pkt_count   <= '0;
      almost_full <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      occupancy   <= occ_nxt;
      pkt_count   <= pkt_nxt;
      almost_full <= (occ_nxt >= CW'(ALMOST_FULL_TH));
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  axis_fifo_ram #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (axis_aclk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: stream instance (32b) and packet instance (64b).
// Queue-based reference model checks every cycle.
module tb_axis_pkt_fifo;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        s_valid;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        m_ready;

  logic        s_rdy_s, s_mv_s, s_ml_s, s_af_s;
  logic [31:0] s_md_s;
  logic [3:0]  s_mk_s;
  logic [4:0]  s_occ_s, s_pc_s;

  logic        s_rdy_p, s_mv_p, s_ml_p, s_af_p;
  logic [63:0] s_md_p;
  logic [7:0]  s_mk_p;
  logic [4:0]  s_occ_p, s_pc_p;

  logic        s_ready, m_valid, m_last, af;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic [4:0]  occ, pcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axis_pkt_fifo #(
    .DATA_WIDTH  (32),
    .DEPTH       (16),
    .PACKET_MODE (0)
  ) u_str (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .s_axis_tvalid (s_valid && !sel),
    .s_axis_tready (s_rdy_s),
    .s_axis_tdata  (s_data[31:0]),
    .s_axis_tkeep  (s_keep[3:0]),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (s_mv_s),
    .m_axis_tready (m_ready && !sel),
    .m_axis_tdata  (s_md_s),
    .m_axis_tkeep  (s_mk_s),
    .m_axis_tlast  (s_ml_s),
    .occupancy     (s_occ_s),
    .pkt_count     (s_pc_s),
    .almost_full   (s_af_s)
  );

  axis_pkt_fifo #(
    .DATA_WIDTH  (64),
    .DEPTH       (16),
    .PACKET_MODE (1)
  ) u_pkt (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .s_axis_tvalid (s_valid && sel),
    .s_axis_tready (s_rdy_p),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (s_mv_p),
    .m_axis_tready (m_ready && sel),
    .m_axis_tdata  (s_md_p),
    .m_axis_tkeep  (s_mk_p),
    .m_axis_tlast  (s_ml_p),
    .occupancy     (s_occ_p),
    .pkt_count     (s_pc_p),
    .almost_full   (s_af_p)
  );

  assign s_ready = sel ? s_rdy_p : s_rdy_s;
  assign m_valid = sel ? s_mv_p : s_mv_s;
  assign m_data  = sel ? s_md_p : {32'h0, s_md_s};
  assign m_keep  = sel ? s_mk_p : {4'h0, s_mk_s};
  assign m_last  = sel ? s_ml_p : s_ml_s;
  assign occ     = sel ? s_occ_p : s_occ_s;
  assign pcnt    = sel ? s_pc_p : s_pc_s;
  assign af      = sel ? s_af_p : s_af_s;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t q[$];
  int    pkts;
  bit    rdy;
  int    npass;
  int    nfail;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, predict the handshakes of the
  // coming edge, update the model, then advance to the next negedge.
  task automatic step(output bit wr, output bit rd);
    bit    er;
    bit    ev;
    int    n;
    beat_t b;
    n  = q.size();
    er = rdy && (n != 16);
    ev = (n != 0) && (!sel || pkts != 0 || n == 16);
    chk("s_ready", s_ready, er);
    chk("m_valid", m_valid, ev);
    chk("occupancy", occ, n);
    chk("pkt_count", pcnt, pkts);
    chk("almost_full", af, n >= 14);
    if (ev) begin
      chk("m_tdata", m_data, q[0].d);
      chk("m_tkeep", m_keep, q[0].k);
      chk("m_tlast", m_last, q[0].l);
    end
    wr = s_valid && er;
    rd = ev && m_ready;
    if (rd) begin
      b = q.pop_front();
      if (b.l) pkts--;
    end
    if (wr) begin
      b.d = sel ? s_data : {32'h0, s_data[31:0]};
      b.k = sel ? s_keep : {4'h0, s_keep[3:0]};
      b.l = s_last;
      q.push_back(b);
      if (s_last) pkts++;
    end
    @(negedge clk);
    if (!rst) rdy = 1'b1;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k,
                      input logic l);
    bit wr;
    bit rd;
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    for (int i = 0; i < 100 && !done; i++) begin
      step(wr, rd);
      done = wr;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bit wr;
    bit rd;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) step(wr, rd);
  endtask

  initial begin
    bit wr;
    bit rd;
    int np;
    int nb;
    int len;
    int guard;
    npass   = 0;
    nfail   = 0;
    pkts    = 0;
    rdy     = 1'b0;
    rst     = 1'b1;
    sel     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    #1;
    for (int m = 0; m < 2; m++) begin
      sel = m[0];
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_occ", occ, 0);
      chk("rst_pkt", pcnt, 0);
      chk("rst_af", af, 0);
    end
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Stream fill to full, then drain in order
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(64'(i), 8'hF, 1'b0);
    chk("full_occ", occ, 16);
    chk("full_af", af, 1);
    s_valid = 1'b1;
    s_data  = 64'h11;
    for (int i = 0; i < 3; i++) step(wr, rd);
    drain(18);
    chk("drained_occ", occ, 0);

    // Simultaneous write and read at occupancy 5, tlast on both
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(64'(32'hA0 + i), 8'h3, 1'b1);
    s_valid = 1'b1;
    s_data  = 64'hBEEF;
    s_keep  = 8'h5;
    s_last  = 1'b1;
    m_ready = 1'b1;
    step(wr, rd);
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("simul_occ", occ, 5);
    chk("simul_pkt", pcnt, 5);
    drain(8);

    // Reset mid-packet at occupancy 7
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(64'(32'hC0 + i), 8'hF, i == 2);
    chk("pre_rst_occ", occ, 7);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_occ", occ, 0);
    chk("arst_pkt", pcnt, 0);
    chk("arst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    pkts = 0;
    rdy  = 1'b0;
    sel  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(64'h5500 + 64'(i), 8'hFF, i == 2);
    drain(6);
    chk("post_rst_occ", occ, 0);

    // Packet mode: 4 beats at one beat per 2 cycles
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send({32'hD00D, 32'(i)}, 8'hF0, i == 3);
      step(wr, rd);
    end
    drain(6);

    // Packet mode: 20-beat packet forces cut-through when full
    m_ready = 1'b1;
    for (int i = 1; i <= 20; i++) send(64'(i) << 8, 8'hAA, i == 20);
    drain(24);
    chk("long_pkt_occ", occ, 0);

    // Random traffic, 1000 packets, packet mode, 64-bit
    np    = 0;
    nb    = 0;
    len   = $urandom_range(8, 1);
    guard = 0;
    s_valid = 1'b0;
    while (np < 1000 && guard < 60000) begin
      if (!s_valid && $urandom_range(1, 0) == 1) begin
        s_valid = 1'b1;
        s_data  = {$urandom, $urandom};
        s_keep  = 8'($urandom);
        s_last  = (nb == len - 1);
      end
      m_ready = 1'($urandom_range(1, 0));
      step(wr, rd);
      guard++;
      if (wr) begin
        s_valid = 1'b0;
        nb++;
        if (nb == len) begin
          np++;
          nb  = 0;
          len = $urandom_range(8, 1);
        end
      end
    end
    s_valid = 1'b0;
    guard   = 0;
    while (q.size() != 0 && guard < 2000) begin
      m_ready = 1'($urandom_range(1, 0));
      step(wr, rd);
      guard++;
    end
    chk("rand_pkts_sent", 64'(np), 64'd1000);
    chk("rand_drain_occ", occ, 0);
    chk("rand_drain_pkt", pcnt, 0);

    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end

endmodule
